// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit:
// op codes, FSM states, datapath step modes and default width.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath (combinational).
// i_acc {upper,lower} 2*XLEN, i_opnd XLEN, i_mode mul/div; o_acc next acc.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  input  step_mode_e        i_mode,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rem;
  logic [XLEN:0] w_diff;

  always_comb begin
    // Multiply: add multiplicand into upper half when the
    // current multiplier bit (acc LSB) is set, then shift right.
    w_sum = {1'b0, i_acc[2*XLEN-1:XLEN]}
          + (i_acc[0] ? {1'b0, i_opnd} : '0);
    // Divide: shift next dividend bit into the remainder,
    // keep the trial difference only if it did not borrow.
    w_rem  = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
    w_diff = w_rem - {1'b0, i_opnd};
    if (i_mode == STEP_MUL) begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end else if (!w_diff[XLEN]) begin
      o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
    end else begin
      o_acc = {w_rem[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide controller: iterative MULT/DIV, MTHI/MTLO.
// Ports: clk, rst(async high), start, op, a, b -> busy, done, hi, lo.
// Option: MULDIV_FAST_MUL_EN gives single-cycle MULT/MULTU.
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_e            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic              r_is_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;

  logic              w_sgn;
  logic              w_neg_ab;
  logic [XLEN-1:0]   w_ma;
  logic [XLEN-1:0]   w_mb;
  logic [2*XLEN-1:0] w_step;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;
  step_mode_e        w_mode;

  always_comb begin
    w_sgn    = (op == OP_MULT) || (op == OP_DIV);
    w_neg_ab = w_sgn & (a[XLEN-1] ^ b[XLEN-1]);
    w_ma     = (w_sgn && a[XLEN-1]) ? -a : a;
    w_mb     = (w_sgn && b[XLEN-1]) ? -b : b;
    w_mode   = r_is_div ? STEP_DIV : STEP_MUL;
    w_prod_fix = r_neg_q ? -r_acc : r_acc;
    w_q_fix  = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_r_fix  = r_neg_r ? -r_acc[2*XLEN-1:XLEN]
                       : r_acc[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_prod;
  assign w_prod = {{XLEN{1'b0}}, w_ma} * {{XLEN{1'b0}}, w_mb};
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .i_mode (w_mode),
    .o_acc  (w_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: r_hi <= a;
              OP_MTLO: r_lo <= a;
              OP_MULT, OP_MULTU: begin
                r_is_div <= 1'b0;
                r_neg_q  <= w_neg_ab;
                r_neg_r  <= 1'b0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                r_acc    <= w_prod;
                r_state  <= S_SIGN;
`else
                r_acc    <= {{XLEN{1'b0}}, w_mb};
                r_opnd   <= w_ma;
                r_state  <= S_CALC;
`endif
              end
              OP_DIV, OP_DIVU: begin
                r_is_div <= 1'b1;
                r_neg_r  <= w_sgn & a[XLEN-1];
                r_cnt    <= '0;
                r_busy   <= 1'b1;
                r_opnd   <= w_mb;
                if (b == '0) begin
                  // Remainder = |a| re-signed back to a;
                  // quotient forced to all ones.
                  r_acc   <= {w_ma, {XLEN{1'b1}}};
                  r_neg_q <= 1'b0;
                  r_state <= S_SIGN;
                end else begin
                  r_acc   <= {{XLEN{1'b0}}, w_ma};
                  r_neg_q <= w_neg_ab;
                  r_state <= S_CALC;
                end
              end
              default: ;
            endcase
          end
        end
        S_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= S_SIGN;
        end
        S_SIGN: begin
          if (r_is_div) begin
            r_lo <= w_q_fix;
            r_hi <= w_r_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
